// File: rtl/ir_frame_tx.sv
// Two-part air-conditioner IR frame transmitter with carrier modulation.
// Sequence: leader, frame A bits, connect gap, frame B bits, stop mark, optional repeats.
// One shared down-counter times every segment. Outputs are registered so that
// env_out and ir_out change on the same clock edge.
module ir_frame_tx #(
  parameter int unsigned CLK_HZ        = 125000000,
  parameter int unsigned CARRIER_HZ    = 38000,
  parameter int unsigned LEN_A         = 35,
  parameter int unsigned LEN_B         = 32,
  parameter int unsigned MSB_FIRST     = 1,
  parameter int unsigned LEAD_MARK_US  = 9000,
  parameter int unsigned LEAD_SPACE_US = 4500,
  parameter int unsigned BIT_MARK_US   = 750,
  parameter int unsigned ZERO_SPACE_US = 450,
  parameter int unsigned ONE_SPACE_US  = 1500,
  parameter int unsigned GAP_SPACE_US  = 20000,
  parameter int unsigned RPT_SPACE_US  = 40000,
  parameter int unsigned CARRIER_EN    = 1,
  parameter int unsigned OUT_INV       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_A-1:0] data_a,
  input  logic [LEN_B-1:0] data_b,
  input  logic [1:0]       repeat_n,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             env_out,
  output logic             ir_out
);

  localparam int unsigned CYC_US   = CLK_HZ / 1000000;
  localparam int unsigned CAR_DIV  = CLK_HZ / CARRIER_HZ;
  localparam int unsigned CAR_HALF = CAR_DIV / 2;

  // Counter preload values: a segment of N cycles is loaded with N-1 and ends at 0.
  localparam logic [31:0] N_LEAD_M = 32'(LEAD_MARK_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_LEAD_S = 32'(LEAD_SPACE_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_BIT_M  = 32'(BIT_MARK_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_ZERO   = 32'(ZERO_SPACE_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_ONE    = 32'(ONE_SPACE_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_GAP    = 32'(GAP_SPACE_US * CYC_US) - 32'd1;
  localparam logic [31:0] N_RPT    = 32'(RPT_SPACE_US * CYC_US) - 32'd1;

  localparam logic CAR_ON = (CARRIER_EN != 0);
  localparam logic INV    = (OUT_INV != 0);
  // LED level on the first cycle of a mark, where the carrier phase restarts at 0.
  localparam logic IR_MARK0 = ((CAR_HALF > 0) || !CAR_ON) ^ INV;

  localparam logic [5:0] A_FIRST = (MSB_FIRST != 0) ? 6'(LEN_A - 1) : 6'd0;
  localparam logic [5:0] A_LAST  = (MSB_FIRST != 0) ? 6'd0 : 6'(LEN_A - 1);
  localparam logic [5:0] B_FIRST = (MSB_FIRST != 0) ? 6'(LEN_B - 1) : 6'd0;
  localparam logic [5:0] B_LAST  = (MSB_FIRST != 0) ? 6'd0 : 6'(LEN_B - 1);

  typedef enum logic [3:0] {
    StIdle, StLeadM, StLeadS, StAM, StAS, StGapM, StGapS, StBM, StBS, StStopM, StRptS
  } state_e;

  state_e           state;
  logic [31:0]      cnt;
  logic [31:0]      phase;
  logic [5:0]       bit_idx;
  logic [1:0]       rpt_left;
  logic [LEN_A-1:0] data_a_q;
  logic [LEN_B-1:0] data_b_q;

  logic [31:0] phase_inc;
  logic        car_inc;
  logic        seg_end;
  logic [63:0] a_pad;
  logic [63:0] b_pad;
  logic        bit_a;
  logic        bit_b;
  logic [5:0]  bit_step;

  // Carrier phase advance, segment end and current payload bit selection.
  always_comb begin
    phase_inc = (phase == 32'(CAR_DIV - 1)) ? 32'd0 : phase + 32'd1;
    car_inc   = (phase_inc < 32'(CAR_HALF));
    seg_end   = (cnt == 32'd0);
    a_pad     = 64'(data_a_q);
    b_pad     = 64'(data_b_q);
    bit_a     = a_pad[bit_idx];
    bit_b     = b_pad[bit_idx];
    bit_step  = (MSB_FIRST != 0) ? bit_idx - 6'd1 : bit_idx + 6'd1;
  end

  // Frame sequencer with segment timer, carrier phase and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      env_out  <= 1'b0;
      ir_out   <= INV;
      cnt      <= '0;
      phase    <= '0;
      bit_idx  <= '0;
      rpt_left <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      // Within a segment: count down, free-run the carrier, keep the envelope.
      done   <= 1'b0;
      cnt    <= cnt - 32'd1;
      phase  <= phase_inc;
      ir_out <= (env_out & (car_inc | ~CAR_ON)) ^ INV;
      if ((state != StIdle) && abort) begin
        state   <= StIdle;
        busy    <= 1'b0;
        env_out <= 1'b0;
        ir_out  <= INV;
        cnt     <= '0;
      end else begin
        case (state)
          StIdle: begin
            cnt <= '0;
            if (start) begin
              data_a_q <= data_a;
              data_b_q <= data_b;
              rpt_left <= repeat_n;
              busy     <= 1'b1;
              state    <= StLeadM;
              env_out  <= 1'b1;
              ir_out   <= IR_MARK0;
              phase    <= '0;
              cnt      <= N_LEAD_M;
            end
          end
          StLeadM: if (seg_end) begin
            state   <= StLeadS;
            env_out <= 1'b0;
            ir_out  <= INV;
            cnt     <= N_LEAD_S;
          end
          StLeadS: if (seg_end) begin
            state   <= StAM;
            bit_idx <= A_FIRST;
            env_out <= 1'b1;
            ir_out  <= IR_MARK0;
            phase   <= '0;
            cnt     <= N_BIT_M;
          end
          StAM: if (seg_end) begin
            state   <= StAS;
            env_out <= 1'b0;
            ir_out  <= INV;
            cnt     <= bit_a ? N_ONE : N_ZERO;
          end
          StAS: if (seg_end) begin
            state   <= (bit_idx == A_LAST) ? StGapM : StAM;
            bit_idx <= bit_step;
            env_out <= 1'b1;
            ir_out  <= IR_MARK0;
            phase   <= '0;
            cnt     <= N_BIT_M;
          end
          StGapM: if (seg_end) begin
            state   <= StGapS;
            env_out <= 1'b0;
            ir_out  <= INV;
            cnt     <= N_GAP;
          end
          StGapS: if (seg_end) begin
            state   <= StBM;
            bit_idx <= B_FIRST;
            env_out <= 1'b1;
            ir_out  <= IR_MARK0;
            phase   <= '0;
            cnt     <= N_BIT_M;
          end
          StBM: if (seg_end) begin
            state   <= StBS;
            env_out <= 1'b0;
            ir_out  <= INV;
            cnt     <= bit_b ? N_ONE : N_ZERO;
          end
          StBS: if (seg_end) begin
            state   <= (bit_idx == B_LAST) ? StStopM : StBM;
            bit_idx <= bit_step;
            env_out <= 1'b1;
            ir_out  <= IR_MARK0;
            phase   <= '0;
            cnt     <= N_BIT_M;
          end
          StStopM: if (seg_end) begin
            env_out <= 1'b0;
            ir_out  <= INV;
            if (rpt_left != 2'd0) begin
              rpt_left <= rpt_left - 2'd1;
              state    <= StRptS;
              cnt      <= N_RPT;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
              done  <= 1'b1;
              cnt   <= '0;
            end
          end
          StRptS: if (seg_end) begin
            state   <= StLeadM;
            env_out <= 1'b1;
            ir_out  <= IR_MARK0;
            phase   <= '0;
            cnt     <= N_LEAD_M;
          end
          default: begin
            state   <= StIdle;
            busy    <= 1'b0;
            env_out <= 1'b0;
            ir_out  <= INV;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_frame_tx.sv
// Self-checking bench for ir_frame_tx. Two instances share all inputs:
// dut0 sends MSB first with the carrier on, dut1 sends LSB first with the
// carrier off. Timings are scaled down so every frame is a few hundred cycles.
module tb_ir_frame_tx;

  localparam int unsigned LA    = 3;
  localparam int unsigned LB    = 2;
  localparam int unsigned T_LM  = 90;
  localparam int unsigned T_LS  = 45;
  localparam int unsigned T_BM  = 8;
  localparam int unsigned T_Z   = 5;
  localparam int unsigned T_O   = 15;
  localparam int unsigned T_GAP = 200;
  localparam int unsigned T_RPT = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LA-1:0] data_a = '0;
  logic [LB-1:0] data_b = '0;
  logic [1:0]    repeat_n = '0;
  logic [1:0]    busy_v;
  logic [1:0]    done_v;
  logic [1:0]    env_v;
  logic [1:0]    ir_v;

  int total = 0;
  int bad = 0;

  bit          mon_en = 1'b0;
  bit          live = 1'b0;
  bit          busy_prev [2];
  bit          run_val [2];
  int unsigned run_len [2];
  int unsigned busy_cnt [2];
  int unsigned done_cnt [2];

  logic        q_val0 [$];
  logic        q_val1 [$];
  int unsigned q_len0 [$];
  int unsigned q_len1 [$];
  int unsigned q_busy0 [$];
  int unsigned q_busy1 [$];

  int unsigned d0;
  int unsigned d1;

  always #5 clk = ~clk;

  ir_frame_tx #(
    .CLK_HZ(1000000), .CARRIER_HZ(100000), .LEN_A(LA), .LEN_B(LB), .MSB_FIRST(1),
    .LEAD_MARK_US(T_LM), .LEAD_SPACE_US(T_LS), .BIT_MARK_US(T_BM), .ZERO_SPACE_US(T_Z),
    .ONE_SPACE_US(T_O), .GAP_SPACE_US(T_GAP), .RPT_SPACE_US(T_RPT), .CARRIER_EN(1), .OUT_INV(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .data_a(data_a), .data_b(data_b),
    .repeat_n(repeat_n), .abort(abort), .busy(busy_v[0]), .done(done_v[0]),
    .env_out(env_v[0]), .ir_out(ir_v[0])
  );

  ir_frame_tx #(
    .CLK_HZ(1000000), .CARRIER_HZ(100000), .LEN_A(LA), .LEN_B(LB), .MSB_FIRST(0),
    .LEAD_MARK_US(T_LM), .LEAD_SPACE_US(T_LS), .BIT_MARK_US(T_BM), .ZERO_SPACE_US(T_Z),
    .ONE_SPACE_US(T_O), .GAP_SPACE_US(T_GAP), .RPT_SPACE_US(T_RPT), .CARRIER_EN(0), .OUT_INV(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .data_a(data_a), .data_b(data_b),
    .repeat_n(repeat_n), .abort(abort), .busy(busy_v[1]), .done(done_v[1]),
    .env_out(env_v[1]), .ir_out(ir_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_seg(input int i, input logic v, input int unsigned n,
                          inout int unsigned tot);
    if (i == 0) begin
      q_val0.push_back(v);
      q_len0.push_back(n);
    end else begin
      q_val1.push_back(v);
      q_len1.push_back(n);
    end
    tot += n;
  endtask

  // Reference envelope of one frame, built from the payload and bit order.
  task automatic push_frame(input int i, input bit msb, input logic [LA-1:0] a,
                            input logic [LB-1:0] b, inout int unsigned tot);
    int unsigned idx;
    push_seg(i, 1'b1, T_LM, tot);
    push_seg(i, 1'b0, T_LS, tot);
    for (int j = 0; j < int'(LA); j++) begin
      idx = msb ? (LA - 1 - j) : j;
      push_seg(i, 1'b1, T_BM, tot);
      push_seg(i, 1'b0, a[idx] ? T_O : T_Z, tot);
    end
    push_seg(i, 1'b1, T_BM, tot);
    push_seg(i, 1'b0, T_GAP, tot);
    for (int j = 0; j < int'(LB); j++) begin
      idx = msb ? (LB - 1 - j) : j;
      push_seg(i, 1'b1, T_BM, tot);
      push_seg(i, 1'b0, b[idx] ? T_O : T_Z, tot);
    end
    push_seg(i, 1'b1, T_BM, tot);
  endtask

  // Expected runs and busy length for a transmission with nrep repeats, both DUTs.
  task automatic plan(input logic [LA-1:0] a, input logic [LB-1:0] b, input int nrep);
    int unsigned tot;
    for (int i = 0; i < 2; i++) begin
      tot = 0;
      for (int r = 0; r <= nrep; r++) begin
        if (r != 0) push_seg(i, 1'b0, T_RPT, tot);
        push_frame(i, (i == 0), a, b, tot);
      end
      if (i == 0) q_busy0.push_back(tot);
      else q_busy1.push_back(tot);
    end
  endtask

  task automatic check_run(input int i, input bit v, input int unsigned n);
    if (i == 0) begin
      if (q_len0.size() == 0) chk("dut0_extra_run", n, 0);
      else begin
        chk("dut0_run_val", 32'(v), 32'(q_val0.pop_front()));
        chk("dut0_run_len", n, q_len0.pop_front());
      end
    end else begin
      if (q_len1.size() == 0) chk("dut1_extra_run", n, 0);
      else begin
        chk("dut1_run_val", 32'(v), 32'(q_val1.pop_front()));
        chk("dut1_run_len", n, q_len1.pop_front());
      end
    end
  endtask

  task automatic check_busy(input int i, input int unsigned n);
    if (i == 0) begin
      if (q_busy0.size() == 0) chk("dut0_extra_busy", n, 0);
      else chk("dut0_busy_len", n, q_busy0.pop_front());
    end else begin
      if (q_busy1.size() == 0) chk("dut1_extra_busy", n, 0);
      else chk("dut1_busy_len", n, q_busy1.pop_front());
    end
  endtask

  task automatic wait_idle(input int unsigned lim);
    int unsigned c;
    c = 0;
    while (busy_v != 2'b00 && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idle_timeout", 32'(busy_v), 0);
  endtask

  // Envelope run monitor: measures each env_out run while busy and scores it.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mon_en) begin
          if (busy_v[i]) begin
            busy_cnt[i]++;
            if (run_len[i] != 0 && env_v[i] == run_val[i]) run_len[i]++;
            else begin
              if (run_len[i] != 0) check_run(i, run_val[i], run_len[i]);
              run_val[i] = env_v[i];
              run_len[i] = 1;
            end
          end else if (busy_prev[i]) begin
            if (run_len[i] != 0) check_run(i, run_val[i], run_len[i]);
            check_busy(i, busy_cnt[i]);
            run_len[i] = 0;
            busy_cnt[i] = 0;
          end
        end else begin
          run_len[i] = 0;
          busy_cnt[i] = 0;
        end
        if (live && done_v[i]) done_cnt[i]++;
        busy_prev[i] = busy_v[i];
      end
      if (live) chk("ir1_follows_env", 32'(ir_v[1]), env_v[1] ? 32'd0 : 32'd1);
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v), 0);
    chk("rst_done", 32'(done_v), 0);
    chk("rst_env", 32'(env_v), 0);
    chk("rst_ir", 32'(ir_v), 3);
    rst = 1'b1;
    live = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic frame plus carrier shape and bit order
    data_a = 3'b101;
    data_b = 2'b01;
    repeat_n = 2'd0;
    plan(3'b101, 2'b01, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy_v), 3);
    chk("start_env", 32'(env_v), 3);
    for (int k = 0; k < int'(T_LM); k++) begin
      chk("lead_carrier", 32'(ir_v[0]), ((k % 10) >= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("lead_space_ir", 32'(ir_v[0]), 1);
    chk("lead_space_env", 32'(env_v[0]), 0);
    repeat (T_LS) @(negedge clk);
    chk("bit_mark_phase_clear", 32'(ir_v[0]), 0);
    chk("bit_mark_env", 32'(env_v[0]), 1);
    repeat (5) @(negedge clk);
    chk("bit_mark_half", 32'(ir_v[0]), 1);
    wait_idle(2000);
    chk("basic_done", 32'(done_v), 3);
    @(negedge clk);
    chk("basic_done_once", 32'(done_v), 0);
    @(negedge clk);

    // Repeats with a start pulse and input changes while busy
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    repeat_n = 2'd2;
    plan(3'b101, 2'b01, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat_n = 2'd0;
    repeat (100) @(negedge clk);
    start = 1'b1;
    data_a = 3'b010;
    data_b = 2'b10;
    repeat_n = 2'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(5000);
    chk("rpt_done", 32'(done_v), 3);
    repeat (2) @(negedge clk);
    chk("rpt_done_count0", done_cnt[0] - d0, 1);
    chk("rpt_done_count1", done_cnt[1] - d1, 1);

    // Abort mid-frame, with start in the same cycle, then a fresh frame
    mon_en = 1'b0;
    data_a = 3'b101;
    data_b = 2'b01;
    repeat_n = 2'd0;
    d0 = done_cnt[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy_v), 0);
    chk("abort_env", 32'(env_v), 0);
    chk("abort_ir", 32'(ir_v), 3);
    chk("abort_done", 32'(done_v), 0);
    @(negedge clk);
    chk("abort_stays_idle", 32'(busy_v), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy_v), 0);
    chk("idle_abort_ir", 32'(ir_v), 3);
    mon_en = 1'b1;
    plan(3'b101, 2'b01, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy_v), 3);
    wait_idle(2000);
    repeat (2) @(negedge clk);
    chk("abort_done_count", done_cnt[0] - d0, 1);

    // Synchronous reset mid-frame
    mon_en = 1'b0;
    d0 = done_cnt[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_v), 0);
    chk("midrst_env", 32'(env_v), 0);
    chk("midrst_ir", 32'(ir_v), 3);
    chk("midrst_done", 32'(done_v), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", 32'(busy_v), 0);
    chk("midrst_done_count", done_cnt[0] - d0, 0);

    // Back-to-back frames with start held high
    mon_en = 1'b1;
    plan(3'b101, 2'b01, 0);
    plan(3'b101, 2'b01, 0);
    start = 1'b1;
    @(negedge clk);
    wait_idle(2000);
    chk("b2b_gap_done", 32'(done_v), 3);
    @(negedge clk);
    chk("b2b_restart_busy", 32'(busy_v), 3);
    chk("b2b_restart_done", 32'(done_v), 0);
    start = 1'b0;
    wait_idle(2000);
    chk("b2b_final_done", 32'(done_v), 3);
    @(negedge clk);
    chk("b2b_final_done_once", 32'(done_v), 0);
    repeat (2) @(negedge clk);

    chk("runs_left", 32'(q_len0.size() + q_len1.size()), 0);
    chk("busy_left", 32'(q_busy0.size() + q_busy1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
